vxc_operand_fetch: RTL

Operand feeder for the complex vector-times-constant-plus-add stage. It reads two complex operand vectors (first row, second row) element by element from two single-port, 1-cycle-latency vector memories. It packs them into no_of_units-lane chunks, zero-padding the tail, and presents each chunk on first_row_fixed / second_row_fixed. The downstream stage requests each following chunk by pulsing read_again.

---
 rtl/vxc_operand_fetch_if.sv | 41 ++++
 rtl/vxc_operand_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vxc_operand_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vxc_operand_fetch_if : control, memory and chunk-output bundle for the     |
// |                        operand feeder.                                     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface vxc_operand_fetch_if #(
  parameter int element_width = 64,
  parameter int no_of_units   = 8,
  parameter int addr_width    = 8
) ();
  logic                                 start;
  logic [addr_width-1:0]                base_a;
  logic [addr_width-1:0]                base_b;
  logic                                 mem_a_re;
  logic [addr_width-1:0]                mem_a_addr;
  logic [element_width-1:0]             mem_a_rdata;
  logic                                 mem_b_re;
  logic [addr_width-1:0]                mem_b_addr;
  logic [element_width-1:0]             mem_b_rdata;
  logic                                 read_again;
  logic [element_width*no_of_units-1:0] first_row_fixed;
  logic [element_width*no_of_units-1:0] second_row_fixed;
  logic                                 chunk_valid;
  logic [7:0]                           chunk_idx;
  logic                                 busy;
  logic                                 done;

  modport master (
    input  start, base_a, base_b, mem_a_rdata, mem_b_rdata, read_again,
    output mem_a_re, mem_a_addr, mem_b_re, mem_b_addr,
           first_row_fixed, second_row_fixed, chunk_valid, chunk_idx, busy, done
  );

  modport slave (
    output start, base_a, base_b, mem_a_rdata, mem_b_rdata, read_again,
    input  mem_a_re, mem_a_addr, mem_b_re, mem_b_addr,
           first_row_fixed, second_row_fixed, chunk_valid, chunk_idx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/vxc_operand_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vxc_operand_fetch : streams two operand vectors from 1-cycle memories into  |
// |                     zero-padded U-lane chunks, one chunk per read_again.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module vxc_operand_fetch #(
  parameter int number_of_equations_per_cluster = 19,
  parameter int element_width                   = 64,
  parameter int no_of_units                     = 8,
  parameter int addr_width                      = 8
) (
  input  logic                clk,
  input  logic                reset,
  vxc_operand_fetch_if.master bus
);

  localparam int N_ELEM   = number_of_equations_per_cluster;
  localparam int EW       = element_width;
  localparam int U        = no_of_units;
  localparam int AW       = addr_width;
  localparam int N_CHUNKS = (N_ELEM + U - 1) / U;
  localparam int LANE_W   = (U > 1) ? $clog2(U) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [7:0]          chunk_q, chunk_d;
  logic [AW-1:0]       base_a_q, base_a_d;
  logic [AW-1:0]       base_b_q, base_b_d;
  logic                prev_re_q, prev_re_d;
  logic [EW*U-1:0]     shadow_a_q, shadow_a_d;
  logic [EW*U-1:0]     shadow_b_q, shadow_b_d;
  logic [EW*U-1:0]     first_row_q, first_row_d;
  logic [EW*U-1:0]     second_row_q, second_row_d;
  logic                chunk_valid_q, chunk_valid_d;
  logic [7:0]          chunk_idx_q, chunk_idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [15:0]         elem_w;
  logic                issue_live_w;
  logic                cap_en_w;
  logic [LANE_W-1:0]   cap_lane_w;

  assign elem_w       = 16'(chunk_q) * 16'(U) + 16'(lane_q);
  assign issue_live_w = (state_q == S_ISSUE) && (elem_w < 16'(N_ELEM));

  // Both memories share the element index; padding lanes issue nothing.
  assign bus.mem_a_re   = issue_live_w;
  assign bus.mem_b_re   = issue_live_w;
  assign bus.mem_a_addr = issue_live_w ? (base_a_q + elem_w[AW-1:0]) : '0;
  assign bus.mem_b_addr = issue_live_w ? (base_b_q + elem_w[AW-1:0]) : '0;

  // Read data lags the issue by one cycle, so capture targets the previous lane.
  assign cap_en_w   = ((state_q == S_ISSUE) && (lane_q != '0)) || (state_q == S_DRAIN);
  assign cap_lane_w = (state_q == S_DRAIN) ? LANE_W'(U - 1) : (lane_q - LANE_W'(1));

  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    chunk_d       = chunk_q;
    base_a_d      = base_a_q;
    base_b_d      = base_b_q;
    prev_re_d     = issue_live_w;
    shadow_a_d    = shadow_a_q;
    shadow_b_d    = shadow_b_q;
    first_row_d   = first_row_q;
    second_row_d  = second_row_q;
    chunk_valid_d = chunk_valid_q;
    chunk_idx_d   = chunk_idx_q;
    done_d        = done_q;

    if (cap_en_w) begin
      shadow_a_d[int'(cap_lane_w)*EW +: EW] = prev_re_q ? bus.mem_a_rdata : '0;
      shadow_b_d[int'(cap_lane_w)*EW +: EW] = prev_re_q ? bus.mem_b_rdata : '0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          base_a_d = bus.base_a;
          base_b_d = bus.base_b;
          chunk_d  = '0;
          lane_d   = '0;
          done_d   = 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (lane_q == LANE_W'(U - 1)) begin
          state_d = S_DRAIN;
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end
      S_DRAIN: begin
        first_row_d   = shadow_a_d;
        second_row_d  = shadow_b_d;
        chunk_idx_d   = chunk_q;
        chunk_valid_d = 1'b1;
        state_d       = S_HOLD;
      end
      S_HOLD: begin
        if (bus.read_again) begin
          chunk_valid_d = 1'b0;
          if (chunk_q == 8'(N_CHUNKS - 1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            chunk_d = chunk_q + 8'd1;
            lane_d  = '0;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lane_q        <= '0;
      chunk_q       <= '0;
      base_a_q      <= '0;
      base_b_q      <= '0;
      prev_re_q     <= 1'b0;
      shadow_a_q    <= '0;
      shadow_b_q    <= '0;
      first_row_q   <= '0;
      second_row_q  <= '0;
      chunk_valid_q <= 1'b0;
      chunk_idx_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      chunk_q       <= chunk_d;
      base_a_q      <= base_a_d;
      base_b_q      <= base_b_d;
      prev_re_q     <= prev_re_d;
      shadow_a_q    <= shadow_a_d;
      shadow_b_q    <= shadow_b_d;
      first_row_q   <= first_row_d;
      second_row_q  <= second_row_d;
      chunk_valid_q <= chunk_valid_d;
      chunk_idx_q   <= chunk_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.first_row_fixed  = first_row_q;
  assign bus.second_row_fixed = second_row_q;
  assign bus.chunk_valid      = chunk_valid_q;
  assign bus.chunk_idx        = chunk_idx_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule
`default_nettype wire
